// File: rtl/ai_issue_controller.sv
// ID/EX issue control: load-use bubble insertion and sequencing of multi-cycle
// AI instructions (freeze, start, wait for done or timeout, release).
module ai_issue_controller #(
   parameter int         CNT_W      = 8,
   parameter int         AI_TIMEOUT = 255,
   parameter logic [6:0] LOAD_OP    = 7'b0000011
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs2,
   input  logic [6:0]  ex_op,
   input  logic [4:0]  ex_rd,
   input  logic        ex_is_ai,
   input  logic [2:0]  ex_ai_opcode,
   input  logic        ai_done,
   output logic        stall_pc,
   output logic        stall_if_id,
   output logic        hold_id_ex,
   output logic        flush_id_ex,
   output logic        ai_start,
   output logic [2:0]  ai_opcode,
   output logic        ai_busy,
   output logic        ai_result_valid,
   output logic        ai_timeout_err,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(AI_TIMEOUT);

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [2:0]       opcode_r, opcode_s;
   logic             err_r, err_s;
   logic [31:0]      stall_cnt_r;
   logic             hazard_s;
   logic             stall_s, hold_s, flush_s, start_s, valid_s;

   assign hazard_s = (ex_op == LOAD_OP) && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

   // Next-state and pipeline-control decode; AI has priority over load-use.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      opcode_s = opcode_r;
      err_s    = err_r;
      stall_s  = 1'b0;
      hold_s   = 1'b0;
      flush_s  = 1'b0;
      start_s  = 1'b0;
      valid_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ex_is_ai) begin
               stall_s  = 1'b1;
               hold_s   = 1'b1;
               opcode_s = ex_ai_opcode;
               state_s  = ST_ISSUE;
            end else if (hazard_s) begin
               stall_s = 1'b1;
               flush_s = 1'b1;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            start_s = 1'b1;
            stall_s = 1'b1;
            hold_s  = 1'b1;
            cnt_s   = {CNT_W{1'b0}};
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            stall_s = 1'b1;
            hold_s  = 1'b1;
            cnt_s   = cnt_r + CNT_W'(1);
            // A done arriving on the timeout cycle is a normal completion.
            if (ai_done) begin
               state_s = ST_DONE;
            end else if (cnt_r == TIMEOUT_C) begin
               err_s   = 1'b1;
               state_s = ST_DONE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            valid_s = 1'b1;
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, wait counter, latched opcode, sticky error and stall statistics.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         opcode_r    <= 3'd0;
         err_r       <= 1'b0;
         stall_cnt_r <= 32'd0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         opcode_r <= opcode_s;
         err_r    <= err_s;
         if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign stall_pc        = stall_s;
   assign stall_if_id     = stall_s;
   assign hold_id_ex      = hold_s;
   assign flush_id_ex     = flush_s;
   assign ai_start        = start_s;
   assign ai_opcode       = opcode_r;
   assign ai_busy         = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
   assign ai_result_valid = valid_s;
   assign ai_timeout_err  = err_r;
   assign stall_cycles    = stall_cnt_r;

endmodule

// File: tb/tb_ai_issue_controller.sv
// Directed bench for ai_issue_controller: vector table for single-cycle decode
// plus hand sequences for back-to-back ops, timeout and reset during WAIT.
module tb_ai_issue_controller;

   localparam logic [6:0] LD = 7'b0000011;

   logic        clk;
   logic        reset_n;
   logic [4:0]  id_rs1, id_rs2;
   logic        id_uses_rs2;
   logic [6:0]  ex_op;
   logic [4:0]  ex_rd;
   logic        ex_is_ai;
   logic [2:0]  ex_ai_opcode;
   logic        ai_done;
   logic        stall_pc, stall_if_id, hold_id_ex, flush_id_ex;
   logic        ai_start, ai_busy, ai_result_valid, ai_timeout_err;
   logic [2:0]  ai_opcode;
   logic [31:0] stall_cycles;

   int errors = 0;
   int checks = 0;

   ai_issue_controller #(.CNT_W(8), .AI_TIMEOUT(4), .LOAD_OP(7'b0000011)) dut (
      .clk(clk), .reset_n(reset_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
      .ex_op(ex_op), .ex_rd(ex_rd), .ex_is_ai(ex_is_ai),
      .ex_ai_opcode(ex_ai_opcode), .ai_done(ai_done),
      .stall_pc(stall_pc), .stall_if_id(stall_if_id),
      .hold_id_ex(hold_id_ex), .flush_id_ex(flush_id_ex),
      .ai_start(ai_start), .ai_opcode(ai_opcode), .ai_busy(ai_busy),
      .ai_result_valid(ai_result_valid), .ai_timeout_err(ai_timeout_err),
      .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        uses2;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic        is_ai;
      logic [2:0]  aop;
      logic        done;
      logic        e_stall;
      logic        e_flush;
      logic        e_hold;
      logic        e_start;
      logic        e_busy;
      logic        e_valid;
      logic [2:0]  e_opc;
      logic [31:0] e_scnt;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // rs1 rs2 u2 op rd ai aop done | stall flush hold start busy valid opc scnt
      vecs[0]  = '{5'd5, 5'd0, 1'b0, LD,       5'd5, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0};
      vecs[1]  = '{5'd0, 5'd0, 1'b0, LD,       5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1};
      vecs[2]  = '{5'd3, 5'd5, 1'b0, LD,       5'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1};
      vecs[3]  = '{5'd3, 5'd5, 1'b1, LD,       5'd5, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1};
      vecs[4]  = '{5'd5, 5'd0, 1'b0, 7'h33,    5'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd2};
      // AI op (also presents a load-use hazard: AI must win, no flush)
      vecs[5]  = '{5'd5, 5'd0, 1'b0, LD,       5'd5, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd2};
      vecs[6]  = '{5'd5, 5'd0, 1'b0, LD,       5'd5, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 32'd3};
      vecs[7]  = '{5'd5, 5'd0, 1'b0, LD,       5'd5, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 32'd4};
      vecs[8]  = '{5'd5, 5'd0, 1'b0, LD,       5'd5, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 32'd5};
      vecs[9]  = '{5'd5, 5'd0, 1'b0, LD,       5'd5, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 32'd6};
      vecs[10] = '{5'd5, 5'd0, 1'b0, LD,       5'd5, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 32'd7};
      vecs[11] = '{5'd0, 5'd0, 1'b0, 7'h00,    5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 32'd7};

      reset_n = 1'b0;
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
      ex_op = 7'd0; ex_rd = 5'd0; ex_is_ai = 1'b0; ex_ai_opcode = 3'd0; ai_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("rst stall_pc", stall_pc, 1'b0);
      chk("rst flush", flush_id_ex, 1'b0);
      chk("rst hold", hold_id_ex, 1'b0);
      chk("rst start", ai_start, 1'b0);
      chk("rst busy", ai_busy, 1'b0);
      chk("rst valid", ai_result_valid, 1'b0);
      chk("rst opcode", ai_opcode, 3'd0);
      chk("rst err", ai_timeout_err, 1'b0);
      chk("rst scnt", stall_cycles, 32'd0);
      next_cyc();

      for (int i = 0; i < 12; i++) begin
         id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_uses_rs2 = vecs[i].uses2;
         ex_op = vecs[i].op; ex_rd = vecs[i].rd; ex_is_ai = vecs[i].is_ai;
         ex_ai_opcode = vecs[i].aop; ai_done = vecs[i].done;
         @(negedge clk);
         chk($sformatf("v%0d stall_pc", i), stall_pc, vecs[i].e_stall);
         chk($sformatf("v%0d stall_if_id", i), stall_if_id, vecs[i].e_stall);
         chk($sformatf("v%0d flush", i), flush_id_ex, vecs[i].e_flush);
         chk($sformatf("v%0d hold", i), hold_id_ex, vecs[i].e_hold);
         chk($sformatf("v%0d start", i), ai_start, vecs[i].e_start);
         chk($sformatf("v%0d busy", i), ai_busy, vecs[i].e_busy);
         chk($sformatf("v%0d valid", i), ai_result_valid, vecs[i].e_valid);
         chk($sformatf("v%0d opcode", i), ai_opcode, vecs[i].e_opc);
         chk($sformatf("v%0d scnt", i), stall_cycles, vecs[i].e_scnt);
         chk($sformatf("v%0d err", i), ai_timeout_err, 1'b0);
         next_cyc();
      end

      // Back-to-back ops; first completes with done on the timeout cycle.
      ex_is_ai = 1'b1; ex_ai_opcode = 3'd3;
      @(negedge clk); chk("b2b idle hold", hold_id_ex, 1'b1);
      next_cyc();
      @(negedge clk); chk("b2b start1", ai_start, 1'b1); chk("b2b opc1", ai_opcode, 3'd3);
      next_cyc();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); chk($sformatf("b2b wait%0d busy", k), ai_busy, 1'b1);
         next_cyc();
      end
      ai_done = 1'b1;
      @(negedge clk); chk("b2b wait4 busy", ai_busy, 1'b1);
      next_cyc();
      ai_done = 1'b0;
      @(negedge clk); chk("b2b valid1", ai_result_valid, 1'b1); chk("b2b coincident err", ai_timeout_err, 1'b0);
      next_cyc();
      ex_ai_opcode = 3'd6;
      @(negedge clk); chk("b2b idle2 stall", stall_pc, 1'b1); chk("b2b idle2 start", ai_start, 1'b0);
      next_cyc();
      @(negedge clk); chk("b2b start2", ai_start, 1'b1); chk("b2b opc2", ai_opcode, 3'd6);
      next_cyc();
      ai_done = 1'b1;
      @(negedge clk); chk("b2b wait busy2", ai_busy, 1'b1);
      next_cyc();
      ai_done = 1'b0;
      @(negedge clk); chk("b2b valid2", ai_result_valid, 1'b1); chk("b2b stall in done", stall_pc, 1'b0);
      next_cyc();
      ex_is_ai = 1'b0;
      @(negedge clk); chk("b2b quiet stall", stall_pc, 1'b0); chk("b2b quiet valid", ai_result_valid, 1'b0);
      next_cyc();

      // Timeout: done never arrives, WAIT counts 0..4.
      ex_is_ai = 1'b1; ex_ai_opcode = 3'd2;
      @(negedge clk); chk("to idle stall", stall_pc, 1'b1);
      next_cyc();
      @(negedge clk); chk("to start", ai_start, 1'b1); chk("to opc", ai_opcode, 3'd2);
      next_cyc();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("to wait%0d busy", k), ai_busy, 1'b1);
         chk($sformatf("to wait%0d err", k), ai_timeout_err, 1'b0);
         chk($sformatf("to wait%0d valid", k), ai_result_valid, 1'b0);
         next_cyc();
      end
      @(negedge clk); chk("to done valid", ai_result_valid, 1'b1); chk("to done err", ai_timeout_err, 1'b1);
      next_cyc();
      ex_is_ai = 1'b0;
      @(negedge clk); chk("to idle busy", ai_busy, 1'b0); chk("to idle stall2", stall_pc, 1'b0);
      chk("to idle err", ai_timeout_err, 1'b1);
      next_cyc();

      // Error is sticky across a normal op.
      ex_is_ai = 1'b1; ex_ai_opcode = 3'd1;
      next_cyc();
      next_cyc();
      ai_done = 1'b1;
      next_cyc();
      ai_done = 1'b0;
      @(negedge clk); chk("sticky valid", ai_result_valid, 1'b1); chk("sticky err", ai_timeout_err, 1'b1);
      next_cyc();
      ex_is_ai = 1'b0;

      // Reset asserted while in WAIT aborts the op.
      ex_is_ai = 1'b1; ex_ai_opcode = 3'd7;
      next_cyc();
      next_cyc();
      @(negedge clk); chk("rw wait busy", ai_busy, 1'b1);
      #2;
      reset_n = 1'b0; ex_is_ai = 1'b0;
      #1;
      chk("rw busy", ai_busy, 1'b0);
      chk("rw stall", stall_pc, 1'b0);
      chk("rw opcode", ai_opcode, 3'd0);
      chk("rw err", ai_timeout_err, 1'b0);
      chk("rw scnt", stall_cycles, 32'd0);
      ai_done = 1'b1;
      next_cyc();
      chk("rw valid in rst", ai_result_valid, 1'b0);
      next_cyc();
      reset_n = 1'b1; ai_done = 1'b0;
      @(negedge clk); chk("rw valid after", ai_result_valid, 1'b0); chk("rw busy after", ai_busy, 1'b0);
      next_cyc();
      @(negedge clk); chk("rw valid after2", ai_result_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ai_issue_controller.md
Name: ai_issue_controller

Overview:
- Pipeline control for the ID/EX stage.
- Detects load-use hazards between decode and EX and inserts a one-cycle bubble into the ID/EX register.
- Sequences multi-cycle AI instructions held in ID/EX: freezes the front end and ID/EX, issues start/opcode to the AI unit, waits for done or timeout, then releases.
- Sits beside the ID/EX pipeline register and drives its hold and flush controls plus the PC and IF/ID stall controls.

Parameters:
- AI_TIMEOUT, 255, WAIT cycles before aborting an AI op; must be < 2^CNT_W.
- CNT_W, 8, width of the AI wait counter.
- LOAD_OP, 7'b0000011, opcode value treated as a load.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 of the instruction in decode.
- id_rs2  in  5  rs2 of the instruction in decode.
- id_uses_rs2  in  1  decode instruction reads rs2.
- ex_op  in  7  opcode held in ID/EX.
- ex_rd  in  5  rd held in ID/EX.
- ex_is_ai  in  1  ID/EX holds an AI instruction.
- ex_ai_opcode  in  3  AI sub-opcode held in ID/EX.
- ai_done  in  1  AI unit completion pulse.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold IF/ID register.
- hold_id_ex  out  1  ID/EX keeps its contents.
- flush_id_ex  out  1  ID/EX loads a bubble (all zero) next edge.
- ai_start  out  1  one-cycle start pulse to the AI unit.
- ai_opcode  out  3  opcode to the AI unit, valid while busy.
- ai_busy  out  1  FSM in ISSUE or WAIT.
- ai_result_valid  out  1  one-cycle pulse; AI result ready for EX/MEM capture.
- ai_timeout_err  out  1  sticky, set on timeout.
- stall_cycles  out  32  count of cycles with stall_pc=1; wraps.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, wait counter=0, ai_opcode=0, ai_timeout_err=0, stall_cycles=0. All other outputs decode to 0 in IDLE with no hazard.
- A reset mid-op aborts the AI op. No ai_result_valid is produced.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, ex_is_ai=1:
  - stall_pc=stall_if_id=hold_id_ex=1.
  - ai_opcode<=ex_ai_opcode.
  - next state ISSUE.
- IDLE, ex_is_ai=0, load-use hazard:
  - Hazard = ex_op==LOAD_OP && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)).
  - stall_pc=stall_if_id=1, flush_id_ex=1, hold_id_ex=0.
  - Stay IDLE. The bubble clears the hazard on the next cycle.
- AI takes priority over load-use. flush_id_ex and hold_id_ex are never both 1.
- ISSUE:
  - ai_start=1 (Moore), stall/hold asserted.
  - Counter cleared; next state WAIT.
  - ai_done is ignored in ISSUE.
- WAIT:
  - stall/hold asserted; counter increments by 1 per cycle.
  - ai_done=1 -> DONE.
  - Otherwise, counter==AI_TIMEOUT -> ai_timeout_err<=1 and DONE.
  - ai_done and timeout in the same cycle: done wins, no error.
- DONE:
  - ai_result_valid=1; stall/hold deasserted so ID/EX loads the next instruction at the end of this cycle.
  - Next state is always IDLE. The old AI op is never re-issued.
  - Back-to-back AI ops re-trigger from IDLE.
- ai_busy = state in {ISSUE, WAIT}.
- stall_cycles increments every cycle stall_pc=1 and wraps at 2^32.
- ai_timeout_err clears only on reset.
- Minimum AI op occupancy: IDLE, ISSUE, WAIT(1), DONE = 4 cycles with done in the first WAIT cycle.
- Front-end stall lasts 3 cycles: IDLE, ISSUE, WAIT.

Test Plan:
- Reset sequencing: hold reset_n=0 two cycles, then release -> all outputs 0, state IDLE; assert reset_n=0 during WAIT -> ai_busy=0 immediately, no ai_result_valid.
- Load-use detection: ex_op=0000011, ex_rd=5, id_rs1=5 -> flush_id_ex=1, stall_pc=1, hold_id_ex=0 for one cycle.
  - Repeat with ex_rd=0 -> no stall.
  - Repeat with id_rs2=5 and id_uses_rs2=0 -> no stall.
- AI op completion: ex_is_ai=1, ex_ai_opcode=3'b101; ai_done 3 cycles after ai_start -> ai_start pulse in cycle 1, ai_opcode=5, ai_result_valid in cycle 5, stall_cycles=5.
- Timeout: AI_TIMEOUT=4, ai_done never asserted -> ai_timeout_err=1 after WAIT counter reaches 4, then DONE, then IDLE; err stays 1 through later ops.
- Back-to-back AI ops: ID/EX presents a second AI op after DONE -> second ai_start occurs 2 cycles after the first ai_result_valid; ai_done coincident with timeout -> no error.
